// File: rtl/ascon_enc_controller_if.sv
// Block handshake, result and datapath-control bundle for the Ascon-128 encryption sequencer.
// master = controller side, slave = caller/datapath side.
interface ascon_enc_controller_if;
    // Caller side
    logic                 i_start;
    logic [127:0]         i_key;
    logic [127:0]         i_nonce;
    logic                 i_has_ad;
    logic                 i_blk_valid;
    logic [63:0]          i_blk_data;
    logic                 i_blk_last;
    logic                 o_blk_ready;
    logic                 o_ct_valid;
    logic [63:0]          o_ct_data;
    logic                 o_tag_valid;
    logic [127:0]         o_tag;
    logic                 o_busy;
    // Datapath controls; o_perm_state[4] is word x0, o_perm_state[0] is word x4
    logic                 o_perm_sys_enable;
    logic                 o_perm_mux_select;
    logic                 o_perm_xor_key_begin;
    logic                 o_perm_xor_data_begin;
    logic                 o_perm_xor_key_end;
    logic                 o_perm_xor_lsb_end;
    logic                 o_perm_cipher_reg;
    logic                 o_perm_tag_reg;
    logic                 o_perm_state_reg;
    logic [3:0]           o_perm_round;
    logic [63:0]          o_perm_data;
    logic [127:0]         o_perm_key;
    logic [4:0][63:0]     o_perm_state;
    logic [63:0]          i_perm_cipher;
    logic [127:0]         i_perm_tag;

    modport master (
        input  i_start, i_key, i_nonce, i_has_ad, i_blk_valid, i_blk_data, i_blk_last,
        input  i_perm_cipher, i_perm_tag,
        output o_blk_ready, o_ct_valid, o_ct_data, o_tag_valid, o_tag, o_busy,
        output o_perm_sys_enable, o_perm_mux_select, o_perm_xor_key_begin,
        output o_perm_xor_data_begin, o_perm_xor_key_end, o_perm_xor_lsb_end,
        output o_perm_cipher_reg, o_perm_tag_reg, o_perm_state_reg, o_perm_round,
        output o_perm_data, o_perm_key, o_perm_state
    );

    modport slave (
        output i_start, i_key, i_nonce, i_has_ad, i_blk_valid, i_blk_data, i_blk_last,
        output i_perm_cipher, i_perm_tag,
        input  o_blk_ready, o_ct_valid, o_ct_data, o_tag_valid, o_tag, o_busy,
        input  o_perm_sys_enable, o_perm_mux_select, o_perm_xor_key_begin,
        input  o_perm_xor_data_begin, o_perm_xor_key_end, o_perm_xor_lsb_end,
        input  o_perm_cipher_reg, o_perm_tag_reg, o_perm_state_reg, o_perm_round,
        input  o_perm_data, o_perm_key, o_perm_state
    );
endinterface

// File: rtl/ascon_enc_controller.sv
// Ascon-128 encryption sequencer: FSM, round counter and block handshake driving a
// one-round-per-cycle permutation datapath through init, AD, plaintext and final phases.
module ascon_enc_controller #(
    parameter int unsigned G_ROUNDS_A = 12,
    parameter int unsigned G_ROUNDS_B = 6,
    parameter logic [63:0] G_IV       = 64'h80400c0600000000
) (
    input  logic                   clock,
    input  logic                   reset,
    ascon_enc_controller_if.master bus
);
    // A p^n permutation runs round indices 12-n .. 11.
    localparam logic [3:0] RoundA0 = 4'(12 - G_ROUNDS_A);
    localparam logic [3:0] RoundB0 = 4'(12 - G_ROUNDS_B);
    localparam logic [3:0] LastA   = 4'(G_ROUNDS_A - 1);
    localparam logic [3:0] LastB   = 4'(G_ROUNDS_B - 1);

    typedef enum logic [2:0] {
        StIdle, StInit, StWaitAd, StWaitPt, StAd, StPt, StFinal, StTag
    } state_e;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] key_q, nonce_q, tag_q;
    logic         has_ad_q, last_q, ct_valid_q, tag_valid_q;
    logic         start_acc, blk_acc, pt_acc;

    // Next-state and per-cycle datapath control decode.
    always_comb begin
        state_d                   = state_q;
        cnt_d                     = cnt_q;
        start_acc                 = 1'b0;
        blk_acc                   = 1'b0;
        pt_acc                    = 1'b0;
        bus.o_blk_ready           = 1'b0;
        bus.o_perm_sys_enable     = 1'b0;
        bus.o_perm_mux_select     = 1'b0;
        bus.o_perm_xor_key_begin  = 1'b0;
        bus.o_perm_xor_data_begin = 1'b0;
        bus.o_perm_xor_key_end    = 1'b0;
        bus.o_perm_xor_lsb_end    = 1'b0;
        bus.o_perm_cipher_reg     = 1'b0;
        bus.o_perm_tag_reg        = 1'b0;
        bus.o_perm_state_reg      = 1'b0;
        bus.o_perm_round          = 4'd0;
        case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    start_acc = 1'b1;
                    cnt_d     = 4'd0;
                    state_d   = StInit;
                end
            end
            StInit: begin
                bus.o_perm_sys_enable = 1'b1;
                bus.o_perm_state_reg  = 1'b1;
                bus.o_perm_mux_select = (cnt_q != 4'd0);  // cnt 0 loads IV/key/nonce
                bus.o_perm_round      = RoundA0 + cnt_q;
                if (cnt_q == LastA) begin
                    bus.o_perm_xor_key_end = 1'b1;
                    bus.o_perm_xor_lsb_end = !has_ad_q;
                    cnt_d                  = 4'd0;
                    state_d                = has_ad_q ? StWaitAd : StWaitPt;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StWaitAd, StWaitPt: begin
                bus.o_perm_sys_enable = 1'b1;
                bus.o_perm_mux_select = 1'b1;
                bus.o_blk_ready       = 1'b1;
                if (bus.i_blk_valid) begin
                    // The accept cycle is already the first round of the block.
                    blk_acc                   = 1'b1;
                    bus.o_perm_state_reg      = 1'b1;
                    bus.o_perm_xor_data_begin = 1'b1;
                    bus.o_perm_round          = RoundB0;
                    cnt_d                     = 4'd1;
                    if (state_q == StWaitAd) begin
                        state_d = StAd;
                    end else begin
                        pt_acc                = 1'b1;
                        bus.o_perm_cipher_reg = 1'b1;
                        if (bus.i_blk_last) begin
                            // Last PT block rolls straight into p^a with the key folded in.
                            bus.o_perm_xor_key_begin = 1'b1;
                            bus.o_perm_round         = RoundA0;
                            state_d                  = StFinal;
                        end else begin
                            state_d = StPt;
                        end
                    end
                end
            end
            StAd, StPt: begin
                bus.o_perm_sys_enable = 1'b1;
                bus.o_perm_mux_select = 1'b1;
                bus.o_perm_state_reg  = 1'b1;
                bus.o_perm_round      = RoundB0 + cnt_q;
                if (cnt_q == LastB) begin
                    cnt_d = 4'd0;
                    if (state_q == StAd) begin
                        bus.o_perm_xor_lsb_end = last_q;  // domain separation after AD
                        state_d                = last_q ? StWaitPt : StWaitAd;
                    end else begin
                        state_d = StWaitPt;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StFinal: begin
                bus.o_perm_sys_enable = 1'b1;
                bus.o_perm_mux_select = 1'b1;
                bus.o_perm_state_reg  = 1'b1;
                bus.o_perm_round      = RoundA0 + cnt_q;
                if (cnt_q == LastA) begin
                    bus.o_perm_xor_key_end = 1'b1;
                    bus.o_perm_tag_reg     = 1'b1;
                    cnt_d                  = 4'd0;
                    state_d                = StTag;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StTag: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state and round counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operands latched at start, block flags and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_q       <= '0;
            nonce_q     <= '0;
            has_ad_q    <= 1'b0;
            last_q      <= 1'b0;
            tag_q       <= '0;
            ct_valid_q  <= 1'b0;
            tag_valid_q <= 1'b0;
        end else begin
            if (start_acc) begin
                key_q    <= bus.i_key;
                nonce_q  <= bus.i_nonce;
                has_ad_q <= bus.i_has_ad;
                tag_q    <= '0;
            end
            if (blk_acc) begin
                last_q <= bus.i_blk_last;
            end
            if (state_q == StTag) begin
                tag_q <= bus.i_perm_tag;
            end
            ct_valid_q  <= pt_acc;
            tag_valid_q <= (state_q == StTag);
        end
    end

    assign bus.o_ct_valid   = ct_valid_q;
    assign bus.o_ct_data    = bus.i_perm_cipher;
    assign bus.o_tag_valid  = tag_valid_q;
    assign bus.o_tag        = tag_q;
    assign bus.o_busy       = (state_q != StIdle);
    assign bus.o_perm_key   = key_q;
    assign bus.o_perm_data  = bus.i_blk_data;
    // Zeroed while idle so nothing stale is presented outside an operation.
    assign bus.o_perm_state = (state_q == StIdle) ? '0 : {G_IV, key_q, nonce_q};
endmodule

// File: tb/tb_ascon_enc_controller.sv
// Testbench for ascon_enc_controller: behavioural Ascon datapath driven by the controller,
// a plain Ascon-128 reference model, and a queue-based scoreboard for ciphertext and tag.
module tb_ascon_enc_controller;
    typedef logic [4:0][63:0] st_t;  // [4] = x0 ... [0] = x4

    localparam logic [63:0]  IV      = 64'h80400c0600000000;
    localparam logic [127:0] KAT_KN  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_TAG = 128'he355159f292911f794cb1432a0103a8a;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    ascon_enc_controller_if bus ();

    ascon_enc_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard queues and stimulus buffers
    logic [63:0]  exp_ct[$];
    logic [127:0] exp_tag[$];
    int           exp_cyc[$];
    logic [63:0]  ad_a[8];
    logic [63:0]  pt_a[8];
    int           wt_a[16];
    logic [127:0] last_tag;
    int           lsb_cnt, mux0_cnt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        total++;
        bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic st_t ascon_round(input st_t s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[4]; x1 = s[3]; x2 = s[2]; x3 = s[1]; x4 = s[0];
        x2 ^= {56'd0, ~r, r};
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        x0 ^= ror(x0, 19) ^ ror(x0, 28);
        x1 ^= ror(x1, 61) ^ ror(x1, 39);
        x2 ^= ror(x2, 1) ^ ror(x2, 6);
        x3 ^= ror(x3, 10) ^ ror(x3, 17);
        x4 ^= ror(x4, 7) ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic st_t perm(input st_t s, input int first);
        st_t t;
        t = s;
        for (int r = first; r < 12; r++) t = ascon_round(t, 4'(r));
        return t;
    endfunction

    // Ascon-128 encryption written straight from the algorithm; pushes expected ciphertexts.
    task automatic ref_model(input logic [127:0] k, input logic [127:0] n, input bit has_ad,
                             input int nad, input int npt, output logic [127:0] tag);
        st_t s;
        s = {IV, k, n};
        s = perm(s, 0);
        s[1] ^= k[127:64];
        s[0] ^= k[63:0];
        if (has_ad) begin
            for (int i = 0; i < nad; i++) begin
                s[4] ^= ad_a[i];
                s = perm(s, 6);
            end
        end
        s[0] ^= 64'd1;
        for (int i = 0; i < npt; i++) begin
            s[4] ^= pt_a[i];
            exp_ct.push_back(s[4]);
            if (i < npt - 1) s = perm(s, 6);
        end
        s[3] ^= k[127:64];
        s[2] ^= k[63:0];
        s = perm(s, 0);
        s[1] ^= k[127:64];
        s[0] ^= k[63:0];
        tag = {s[1], s[0]};
    endtask

    // Behavioural round datapath obeying the controller's per-cycle controls.
    st_t          dp_s, e_in, e_out;
    logic [63:0]  dp_c;
    logic [127:0] dp_t;

    always_comb begin
        e_in = bus.o_perm_mux_select ? dp_s : bus.o_perm_state;
        if (bus.o_perm_xor_data_begin) e_in[4] = e_in[4] ^ bus.o_perm_data;
        if (bus.o_perm_xor_key_begin) begin
            e_in[3] = e_in[3] ^ bus.o_perm_key[127:64];
            e_in[2] = e_in[2] ^ bus.o_perm_key[63:0];
        end
        e_out = ascon_round(e_in, bus.o_perm_round);
        if (bus.o_perm_xor_key_end) begin
            e_out[1] = e_out[1] ^ bus.o_perm_key[127:64];
            e_out[0] = e_out[0] ^ bus.o_perm_key[63:0];
        end
        if (bus.o_perm_xor_lsb_end) e_out[0] = e_out[0] ^ 64'd1;
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            dp_s <= '0;
            dp_c <= '0;
            dp_t <= '0;
        end else if (!bus.o_perm_sys_enable) begin
            dp_s <= '0;
        end else begin
            if (bus.o_perm_state_reg) dp_s <= e_out;
            if (bus.o_perm_cipher_reg) dp_c <= e_in[4];
            if (bus.o_perm_tag_reg) dp_t <= {e_out[1], e_out[0]};
        end
    end

    assign bus.i_perm_cipher = dp_c;
    assign bus.i_perm_tag    = dp_t;

    // Monitor: pops expectations whenever the DUT presents a ciphertext or tag.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.o_perm_sys_enable && bus.o_perm_xor_lsb_end) begin
                lsb_cnt++;
                check("lsb_round", 128'(bus.o_perm_round), 128'd11);
            end
            if (bus.o_perm_sys_enable && !bus.o_perm_mux_select) mux0_cnt++;
            if (bus.o_ct_valid) begin
                if (exp_ct.size() == 0) fail_now("ct_unexpected", "got ct_valid=1 expected 0");
                else check("ct_data", 128'(bus.o_ct_data), 128'(exp_ct.pop_front()));
            end
            if (bus.o_tag_valid) begin
                last_tag = bus.o_tag;
                if (exp_tag.size() == 0 || exp_cyc.size() == 0) begin
                    fail_now("tag_unexpected", "got tag_valid=1 expected 0");
                end else begin
                    check("tag", bus.o_tag, exp_tag.pop_front());
                    check("tag_cycle", 128'(cyc), 128'(exp_cyc.pop_front()));
                    check("lsb_count", 128'(lsb_cnt), 128'd1);
                    check("mux0_count", 128'(mux0_cnt), 128'd1);
                end
            end
            if (!bus.o_busy) begin
                lsb_cnt  = 0;
                mux0_cnt = 0;
            end
        end
    end

    task automatic check_idle(input string name);
        check({name, "_ctl"}, 128'({bus.o_busy, bus.o_blk_ready, bus.o_ct_valid, bus.o_tag_valid,
              bus.o_perm_sys_enable, bus.o_perm_mux_select, bus.o_perm_xor_key_begin,
              bus.o_perm_xor_data_begin, bus.o_perm_xor_key_end, bus.o_perm_xor_lsb_end,
              bus.o_perm_cipher_reg, bus.o_perm_tag_reg, bus.o_perm_state_reg,
              bus.o_perm_round}), 128'd0);
        check({name, "_tag"}, bus.o_tag, 128'd0);
        check({name, "_key"}, bus.o_perm_key, 128'd0);
        check({name, "_st"}, 128'(|bus.o_perm_state), 128'd0);
        check({name, "_ct"}, 128'(bus.o_ct_data), 128'd0);
    endtask

    // One full encryption: expectations pushed first, then blocks driven with waits wt_a[].
    task automatic run_txn(input logic [127:0] k, input logic [127:0] n, input bit has_ad,
                           input int nad, input int npt, input bit poke);
        logic [127:0] tag;
        int s, sumw, nb, w;
        bit ok, is_ad, last;
        int idx;
        ref_model(k, n, has_ad, nad, npt, tag);
        exp_tag.push_back(tag);
        nb   = (has_ad ? nad : 0) + npt;
        sumw = 0;
        @(negedge clock);
        bus.i_start  = 1'b1;
        bus.i_key    = k;
        bus.i_nonce  = n;
        bus.i_has_ad = has_ad;
        s = cyc;
        @(negedge clock);
        bus.i_start  = 1'b0;
        bus.i_key    = {$urandom, $urandom, $urandom, $urandom};
        bus.i_nonce  = {$urandom, $urandom, $urandom, $urandom};
        bus.i_has_ad = 1'($urandom);
        #1 check("busy_after_start", 128'(bus.o_busy), 128'd1);
        for (int b = 0; b < nb; b++) begin
            is_ad = has_ad && (b < nad);
            idx   = is_ad ? b : b - (has_ad ? nad : 0);
            last  = is_ad ? (idx == nad - 1) : (idx == npt - 1);
            ok    = 1'b0;
            for (int t = 0; t < 40; t++) begin
                if (bus.o_blk_ready) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clock);
            end
            if (!ok) begin
                fail_now("ready_timeout", "got blk_ready=0 for 40 cycles expected 1");
                return;
            end
            w = wt_a[b];
            sumw += w;
            bus.i_blk_valid = 1'b0;
            for (int i = 0; i < w; i++) begin
                #1 check("wait_state_reg", 128'(bus.o_perm_state_reg), 128'd0);
                @(negedge clock);
            end
            bus.i_blk_valid = 1'b1;
            bus.i_blk_data  = is_ad ? ad_a[idx] : pt_a[idx];
            bus.i_blk_last  = last;
            @(negedge clock);
            bus.i_blk_valid = 1'b0;
            bus.i_blk_data  = {$urandom, $urandom};
            bus.i_blk_last  = 1'($urandom);
            if (poke && (is_ad || last)) begin
                // A start pulse mid-operation must be ignored.
                bus.i_start = 1'b1;
                bus.i_key   = {$urandom, $urandom, $urandom, $urandom};
                #1 check("busy_poke", 128'(bus.o_busy), 128'd1);
                @(negedge clock);
                bus.i_start = 1'b0;
            end
        end
        exp_cyc.push_back(s + 13 + sumw + 6 * (nb - 1) + 13);
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clock);
            if (!bus.o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("busy_timeout", "got busy=1 for 60 cycles expected 0");
        #1;
    endtask

    task automatic run_kat(input int wait0);
        pt_a[0] = 64'h8000000000000000;
        wt_a[0] = wait0;
        run_txn(KAT_KN, KAT_KN, 1'b0, 0, 1, 1'b0);
        check("kat_tag", last_tag, KAT_TAG);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 ns expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k, n;
        bit           had;
        int           nad, npt;
        bus.i_start     = 1'b0;
        bus.i_key       = '0;
        bus.i_nonce     = '0;
        bus.i_has_ad    = 1'b0;
        bus.i_blk_valid = 1'b0;
        bus.i_blk_data  = '0;
        bus.i_blk_last  = 1'b0;
        last_tag        = '0;
        lsb_cnt         = 0;
        mux0_cnt        = 0;
        for (int i = 0; i < 16; i++) wt_a[i] = 0;
        repeat (3) @(negedge clock);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clock);
        #1 check_idle("idle");

        // Known-answer vector, then the same with 7 cycles of backpressure.
        run_kat(0);
        run_kat(7);

        // Reset while INIT is at cnt=5 aborts with no partial outputs.
        @(negedge clock);
        bus.i_start  = 1'b1;
        bus.i_key    = KAT_KN;
        bus.i_nonce  = KAT_KN;
        bus.i_has_ad = 1'b0;
        @(negedge clock);
        bus.i_start  = 1'b0;
        repeat (5) @(negedge clock);
        check("init_round5", 128'(bus.o_perm_round), 128'd5);
        reset = 1'b1;
        #1 check_idle("abort");
        @(negedge clock);
        check_idle("abort_next");
        reset = 1'b0;
        run_kat(0);

        // Two AD blocks and two PT blocks.
        for (int i = 0; i < 2; i++) begin
            ad_a[i] = {$urandom, $urandom};
            pt_a[i] = {$urandom, $urandom};
        end
        for (int i = 0; i < 4; i++) wt_a[i] = i;
        run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                1'b1, 2, 2, 1'b0);

        // Same shape with stray start pulses during AD and FINAL.
        run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                1'b1, 2, 2, 1'b1);

        // Randomized operations.
        for (int t = 0; t < 10; t++) begin
            k   = {$urandom, $urandom, $urandom, $urandom};
            n   = {$urandom, $urandom, $urandom, $urandom};
            had = 1'($urandom);
            nad = 1 + int'($urandom_range(0, 2));
            npt = 1 + int'($urandom_range(0, 2));
            for (int i = 0; i < 8; i++) begin
                ad_a[i] = {$urandom, $urandom};
                pt_a[i] = {$urandom, $urandom};
            end
            for (int i = 0; i < 16; i++) wt_a[i] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
            run_txn(k, n, had, nad, npt, 1'($urandom));
        end

        repeat (5) @(negedge clock);
        check("ct_queue_empty", 128'(exp_ct.size()), 128'd0);
        check("tag_queue_empty", 128'(exp_tag.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
